// File: rtl/sha_accel_pkg.sv
// Shared definitions for the SHA-256 PCPI accelerator: opcode constants,
// FSM states and the SHA-256 sigma functions.
package sha_accel_pkg;

    localparam logic [6:0] CUSTOM0     = 7'b0001011;
    localparam int         WIN_ENTRIES = 16;

    typedef enum logic [2:0] {
        OP_SSIG0  = 3'd0,
        OP_SSIG1  = 3'd1,
        OP_BSIG0  = 3'd2,
        OP_BSIG1  = 3'd3,
        OP_WPUSH  = 3'd4,
        OP_WNEXT  = 3'd5,
        OP_WRESET = 3'd6,
        OP_PERF   = 3'd7
    } sha_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_COOL
    } state_e;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

endpackage

// File: rtl/sha_sched_window.sv
// SHA-256 message-schedule window: 16-entry circular buffer with the
// W[t] = sig1(W[t-2]) + W[t-7] + sig0(W[t-15]) + W[t-16] datapath.
module sha_sched_window
    import sha_accel_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        push_i,
    input  logic [31:0] push_data_i,
    input  logic        clear_i,
    output logic [31:0] next_w_o,
    output logic        full_o
);

    logic [31:0] mem_q [WIN_ENTRIES];
    logic [3:0]  ptr_q, ptr_d;
    logic [4:0]  count_q, count_d;
    logic [3:0]  idx_m2, idx_m7, idx_m15;

    // ptr_q is the next write slot, so it also addresses the oldest entry W[-16].
    assign idx_m2  = ptr_q - 4'd2;
    assign idx_m7  = ptr_q - 4'd7;
    assign idx_m15 = ptr_q - 4'd15;

    assign next_w_o = ssig1(mem_q[idx_m2]) + mem_q[idx_m7]
                    + ssig0(mem_q[idx_m15]) + mem_q[ptr_q];
    assign full_o   = (count_q == 5'd16);

    // NOTE: the buffer is deliberately not reset; count_q gates every read.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[ptr_q] <= push_data_i;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        if (clear_i) begin
            ptr_d   = '0;
            count_d = '0;
        end else if (push_i) begin
            ptr_d   = ptr_q + 4'd1;
            count_d = full_o ? count_q : count_q + 5'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pcpi_sha_seq.sv
// Multi-cycle PCPI SHA-256 coprocessor (custom-0). Define SHA_ACCEL_PERF_EN
// to enable the BUSY-cycle performance counter read by funct3=7.
module pcpi_sha_seq
    import sha_accel_pkg::*;
#(
    parameter int         LATENCY   = 2,
    parameter logic [6:0] FUNCT7    = 7'b0000001,
    parameter int         WIN_DEPTH = 16
)
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready
);

    if (WIN_DEPTH != WIN_ENTRIES) begin : g_bad_depth
        $error("pcpi_sha_seq: WIN_DEPTH must be 16");
    end
    if (LATENCY < 1 || LATENCY > 16) begin : g_bad_latency
        $error("pcpi_sha_seq: LATENCY must be within 1..16");
    end

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    sha_op_e     op_q;
    logic [31:0] rs1_q, rd_hold_q, result;
    logic        f3_ok, match, accept, commit;
    logic        win_push, win_clear, win_full;
    logic [31:0] win_data, win_next;
    logic        unused_bits;

    assign unused_bits = ^{pcpi_rs2, pcpi_insn[24:15], pcpi_insn[11:7]};

`ifdef SHA_ACCEL_PERF_EN
    assign f3_ok = 1'b1;
`else
    assign f3_ok = (pcpi_insn[14:12] != OP_PERF);
`endif

    assign match = pcpi_valid && (pcpi_insn[6:0] == CUSTOM0)
                && (pcpi_insn[31:25] == FUNCT7) && f3_ok;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: if (match) begin
                accept  = 1'b1;
                cnt_d   = CNT_INIT;
                state_d = ST_BUSY;
            end
            // Core dropping valid mid-op is an abort: no ready, no window commit.
            ST_BUSY: if (!pcpi_valid) begin
                state_d = ST_IDLE;
            end else if (cnt_q == 4'd0) begin
                commit  = 1'b1;
                state_d = ST_COOL;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            // COOL swallows the still-held valid of the just-completed op.
            ST_COOL: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef SHA_ACCEL_PERF_EN
    logic [31:0] perf_cnt_q, perf_snap_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_cnt_q  <= '0;
            perf_snap_q <= '0;
        end else begin
            if (commit && op_q == OP_PERF && rs1_q[0]) begin
                perf_cnt_q <= '0;
            end else if (state_q == ST_BUSY) begin
                perf_cnt_q <= perf_cnt_q + 32'd1;
            end
            if (accept) begin
                perf_snap_q <= perf_cnt_q;
            end
        end
    end
`endif

    always_comb begin
        result = '0;
        case (op_q)
            OP_SSIG0:  result = ssig0(rs1_q);
            OP_SSIG1:  result = ssig1(rs1_q);
            OP_BSIG0:  result = bsig0(rs1_q);
            OP_BSIG1:  result = bsig1(rs1_q);
            OP_WPUSH:  result = rs1_q;
            OP_WNEXT:  result = win_full ? win_next : '0;
`ifdef SHA_ACCEL_PERF_EN
            OP_PERF:   result = perf_snap_q;
`endif
            default:   result = '0;
        endcase
    end

    assign win_push  = commit && (op_q == OP_WPUSH || (op_q == OP_WNEXT && win_full));
    assign win_clear = commit && (op_q == OP_WRESET);
    assign win_data  = (op_q == OP_WNEXT) ? win_next : rs1_q;

    sha_sched_window u_window (
        .clk         (clk),
        .resetn      (resetn),
        .push_i      (win_push),
        .push_data_i (win_data),
        .clear_i     (win_clear),
        .next_w_o    (win_next),
        .full_o      (win_full)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= OP_SSIG0;
            rs1_q     <= '0;
            rd_hold_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                op_q  <= sha_op_e'(pcpi_insn[14:12]);
                rs1_q <= pcpi_rs1;
            end
            if (commit) begin
                rd_hold_q <= result;
            end
        end
    end

    assign pcpi_wait  = (state_q == ST_BUSY);
    assign pcpi_ready = commit;
    assign pcpi_wr    = commit;
    assign pcpi_rd    = commit ? result : rd_hold_q;

endmodule
